rep_pulse_gen: RTL and testbench

//  Synthesizable generator for bounded-repetition pulse trains on b_o.
//  A rising edge on trig_i emits count_i one-cycle pulses on b_o, spaced gap_i cycles apart.

---
 rtl/rep_pulse_if.sv | 29 ++
 rtl/rep_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_rep_pulse_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rep_pulse_if.sv
// Bundled trigger/config inputs and pulse-train outputs of the repetition pulse generator.
// The master drives triggers and configuration; the slave is the generator itself.
interface rep_pulse_if #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             trig_i;
  logic [CNT_W-1:0] count_i;
  logic [GAP_W-1:0] gap_i;
  logic [GAP_W-1:0] tail_i;
  logic             mode_i;
  logic             en_i;
  logic             abort_i;
  logic             b_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [CNT_W-1:0] pulse_cnt_o;

  modport master (
    output trig_i, count_i, gap_i, tail_i, mode_i, en_i, abort_i,
    input  b_o, busy_o, done_o, aborted_o, pulse_cnt_o
  );

  modport slave (
    input  trig_i, count_i, gap_i, tail_i, mode_i, en_i, abort_i,
    output b_o, busy_o, done_o, aborted_o, pulse_cnt_o
  );
endinterface

// File: rtl/rep_pulse_gen.sv
// Bounded-repetition pulse train generator: on a trigger rise, emits count one-cycle
// pulses spaced gap cycles apart, optionally followed by tail idle cycles.
module rep_pulse_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rep_pulse_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_GAP, S_TAIL, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic             trig_q_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [GAP_W-1:0] tail_reg, tail_next;
  logic             mode_reg, mode_next;
  logic [GAP_W-1:0] tmr_reg, tmr_next;
  logic [CNT_W-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic             b_reg, busy_reg, done_reg, aborted_reg;
  logic             aborted_next;
  logic             rise;
  logic             in_train;

  assign rise     = bus.trig_i & ~trig_q_reg;
  assign in_train = (state_reg == S_PULSE) || (state_reg == S_GAP) || (state_reg == S_TAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      trig_q_reg    <= 1'b0;
      count_reg     <= '0;
      gap_reg       <= '0;
      tail_reg      <= '0;
      mode_reg      <= 1'b0;
      tmr_reg       <= '0;
      pulse_cnt_reg <= '0;
      b_reg         <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      trig_q_reg    <= bus.trig_i;
      count_reg     <= count_next;
      gap_reg       <= gap_next;
      tail_reg      <= tail_next;
      mode_reg      <= mode_next;
      tmr_reg       <= tmr_next;
      pulse_cnt_reg <= pulse_cnt_next;
      b_reg         <= (state_next == S_PULSE);
      busy_reg      <= (state_next == S_PULSE) || (state_next == S_GAP) || (state_next == S_TAIL);
      done_reg      <= (state_next == S_DONE);
      aborted_reg   <= aborted_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    gap_next       = gap_reg;
    tail_next      = tail_reg;
    mode_next      = mode_reg;
    tmr_next       = tmr_reg;
    pulse_cnt_next = pulse_cnt_reg;
    aborted_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rise && !bus.abort_i) begin
          count_next     = bus.count_i;
          gap_next       = bus.gap_i;
          tail_next      = bus.tail_i;
          mode_next      = bus.mode_i;
          pulse_cnt_next = '0;
          if (bus.count_i == '0) begin
            state_next = S_DONE;
          end else if (bus.en_i) begin
            state_next     = S_PULSE;
            pulse_cnt_next = CNT_W'(1);
          end else begin
            // Counter 0 makes the first pulse fire as soon as en_i returns.
            state_next = S_GAP;
            tmr_next   = '0;
          end
        end
      end
      S_PULSE: begin
        if (pulse_cnt_reg == count_reg) begin
          if (mode_reg && (tail_reg != '0)) begin
            state_next = S_TAIL;
            tmr_next   = tail_reg;
          end else begin
            state_next = S_DONE;
          end
        end else if ((gap_reg == '0) && bus.en_i) begin
          pulse_cnt_next = pulse_cnt_reg + CNT_W'(1);
        end else begin
          state_next = S_GAP;
          tmr_next   = gap_reg;
        end
      end
      S_GAP: begin
        // The counter value is the number of idle cycles still to show, this one included.
        if (bus.en_i) begin
          if (tmr_reg <= GAP_W'(1)) begin
            state_next     = S_PULSE;
            pulse_cnt_next = pulse_cnt_reg + CNT_W'(1);
          end else begin
            tmr_next = tmr_reg - GAP_W'(1);
          end
        end
      end
      S_TAIL: begin
        if (bus.en_i) begin
          if (tmr_reg <= GAP_W'(1)) begin
            state_next = S_DONE;
          end else begin
            tmr_next = tmr_reg - GAP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (bus.abort_i && in_train) begin
      state_next     = S_IDLE;
      tmr_next       = tmr_reg;
      pulse_cnt_next = pulse_cnt_reg;
      aborted_next   = 1'b1;
    end
  end

  assign bus.b_o         = b_reg;
  assign bus.busy_o      = busy_reg;
  assign bus.done_o      = done_reg;
  assign bus.aborted_o   = aborted_reg;
  assign bus.pulse_cnt_o = pulse_cnt_reg;

endmodule

// File: tb/tb_rep_pulse_gen.sv
// Scoreboard bench for rep_pulse_gen: each train pushes its expected pulse map and
// end strobe; a monitor pops and compares when done_o or aborted_o appears.
`timescale 1ns/1ps
module tb_rep_pulse_gen;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  typedef struct {
    string       name;
    int          e0;
    bit          is_abort;
    int          end_off;
    logic [31:0] mask;
    int          cnt;
    int          busy_last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   free_run = 0;
  exp_t sb[$];

  logic [31:0] acc_mask = '0;
  int          acc_busy = 0;

  rep_pulse_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  rep_pulse_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: accumulate the pulse map of the front train, compare on its end strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0) begin
        int off;
        off = cyc - sb[0].e0;
        if (bus.b_o && off >= 0 && off < 32) acc_mask[off] = 1'b1;
        if (bus.busy_o) acc_busy = off;
      end else if (!free_run) begin
        check("idle_quiet", 32'(bus.b_o | bus.busy_o), 32'd0);
      end
      if (bus.done_o || bus.aborted_o) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, bus.done_o, bus.aborted_o}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_kind"}, {30'd0, bus.done_o, bus.aborted_o},
                e.is_abort ? 32'd1 : 32'd2);
          check({e.name, "_end"}, 32'(cyc - e.e0), 32'(e.end_off));
          check({e.name, "_mask"}, acc_mask, e.mask);
          check({e.name, "_cnt"}, 32'(bus.pulse_cnt_o), 32'(e.cnt));
          check({e.name, "_busy"}, 32'(acc_busy), 32'(e.busy_last));
          $display("txn %s: %s at +%0d pulses=%h cnt=%0d last_busy=+%0d", e.name,
                   bus.aborted_o ? "aborted" : "done", cyc - e.e0, acc_mask,
                   bus.pulse_cnt_o, acc_busy);
          acc_mask = '0;
          acc_busy = 0;
        end
      end
    end
  end

  function automatic logic en_at(input int k, input int s, input int len);
    return !(k >= s && k < s + len);
  endfunction

  // Drives one train; cycle k after the push is cycle E0+k.
  task automatic run_train(input string nm, input int cnt, input int gap, input int tail,
                           input int md, input int en_s, input int en_len,
                           input int abort_at, input int retrig_at, input bit push,
                           input bit ex_abort, input int ex_end, input logic [31:0] ex_mask,
                           input int ex_cnt, input int ex_busy, input int run_len);
    exp_t e;
    @(negedge clk);
    bus.count_i = CNT_W'(cnt);
    bus.gap_i   = GAP_W'(gap);
    bus.tail_i  = GAP_W'(tail);
    bus.mode_i  = md[0];
    bus.trig_i  = 1'b1;
    bus.en_i    = en_at(0, en_s, en_len);
    bus.abort_i = (abort_at == 0);
    if (push) begin
      e.name = nm; e.e0 = cyc; e.is_abort = ex_abort; e.end_off = ex_end;
      e.mask = ex_mask; e.cnt = ex_cnt; e.busy_last = ex_busy;
      sb.push_back(e);
    end
    for (int k = 1; k <= run_len; k++) begin
      @(negedge clk);
      bus.trig_i  = (k == retrig_at);
      bus.en_i    = en_at(k, en_s, en_len);
      bus.abort_i = (k == abort_at);
    end
    bus.trig_i  = 1'b0;
    bus.en_i    = 1'b1;
    bus.abort_i = 1'b0;
    if (push) begin
      @(negedge clk);
      check({nm, "_cnt_hold"}, 32'(bus.pulse_cnt_o), 32'(ex_cnt));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.trig_i = 1'b0; bus.count_i = '0; bus.gap_i = '0; bus.tail_i = '0;
    bus.mode_i = 1'b0; bus.en_i = 1'b1; bus.abort_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_b", 32'(bus.b_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_aborted", 32'(bus.aborted_o), 32'd0);
    check("rst_cnt", 32'(bus.pulse_cnt_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //         name      cnt gap tail md en_s len abt rtr push abt end mask      cnt busy run
    run_train("t1_goto",   3, 2, 0, 0, 0, 0, -1, -1, 1, 0,  8, 32'h92,  3, 7, 10);
    run_train("t2_tail",   3, 2, 4, 1, 0, 0, -1, -1, 1, 0, 12, 32'h92,  3, 11, 14);
    run_train("t3_b2b",    3, 0, 0, 0, 0, 0, -1, -1, 1, 0,  4, 32'hE,   3, 3, 6);
    run_train("t3_zero",   0, 2, 0, 0, 0, 0, -1, -1, 1, 0,  1, 32'h0,   0, 0, 3);
    run_train("t4_en",     3, 2, 0, 0, 2, 2, -1, -1, 1, 0, 10, 32'h242, 3, 9, 12);
    run_train("t5_abort",  3, 2, 0, 0, 0, 0,  2, -1, 1, 1,  3, 32'h2,   1, 2, 5);
    run_train("t6_retrig", 3, 2, 0, 0, 0, 0, -1,  3, 1, 0,  8, 32'h92,  3, 7, 10);
    run_train("m1_notail", 2, 1, 0, 1, 0, 0, -1, -1, 1, 0,  4, 32'hA,   2, 3, 6);
    run_train("en_first",  2, 1, 0, 0, 0, 2, -1, -1, 1, 0,  6, 32'h28,  2, 5, 8);

    // A rise coincident with abort in IDLE must not start a train.
    @(negedge clk);
    bus.count_i = CNT_W'(3); bus.gap_i = GAP_W'(2); bus.mode_i = 1'b0;
    bus.trig_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.trig_i = 1'b0; bus.abort_i = 1'b0;
    check("abort_rise_busy", 32'(bus.busy_o), 32'd0);
    check("abort_rise_b", 32'(bus.b_o), 32'd0);
    repeat (2) @(negedge clk);

    // Reset asserted while the train sits in TAIL, then a clean train.
    free_run = 1'b1;
    run_train("rst_mid", 3, 2, 4, 1, 0, 0, -1, -1, 0, 0, 0, 32'h0, 0, 0, 9);
    check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_b", 32'(bus.b_o), 32'd0);
    check("arst_busy", 32'(bus.busy_o), 32'd0);
    check("arst_done", 32'(bus.done_o), 32'd0);
    check("arst_aborted", 32'(bus.aborted_o), 32'd0);
    check("arst_cnt", 32'(bus.pulse_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    free_run = 1'b0;
    run_train("post_rst", 3, 2, 0, 0, 0, 0, -1, -1, 1, 0, 8, 32'h92, 3, 7, 10);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
